// File: rtl/wm_embed_pkg.sv
// ---------------------------------------------------------------------------
// wm_embed_pkg
// Shared definitions for the watermark embedding block: the frame FSM state
// encoding, the grayscale pixel width and the default frame geometry.
// Also provides a helper that sizes the column/row counters.
// ---------------------------------------------------------------------------
package wm_embed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIX_W         = 8;
  localparam int DEFAULT_IMG_W = 256;
  localparam int DEFAULT_IMG_H = 256;

  // A single-line frame (IMG_H = 1) would give a zero-width row counter,
  // so every counter keeps at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wm_lsb_insert.sv
// ---------------------------------------------------------------------------
// wm_lsb_insert
// Combinational LSB substitution of watermark bits into a cover pixel.
// Ports:
//   mode     in   1      1 = replace two LSBs, 0 = replace one LSB
//   wm_data  in   2      watermark bits
//   pix_in   in   PIX_W  cover pixel
//   pix_out  out  PIX_W  watermarked pixel
// ---------------------------------------------------------------------------
module wm_lsb_insert
  import wm_embed_pkg::*;
(
  input  logic             mode,
  input  logic [1:0]       wm_data,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] pix_out
);

  // In 1-bit mode only wm_data[0] is used; bit 1 of the cover pixel survives.
  always_comb begin
    pix_out = pix_in;
    if (mode) begin
      pix_out = {pix_in[PIX_W-1:2], wm_data[1:0]};
    end else begin
      pix_out = {pix_in[PIX_W-1:1], wm_data[0]};
    end
  end

endmodule

// File: rtl/wm_embed.sv
// ---------------------------------------------------------------------------
// wm_embed
// Streams one grayscale frame through an LSB watermark embedder with a
// single-entry output register and valid/ready handshakes on both sides.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, begins a frame when idle
//   WM_select           embedding mode, latched at frame start (1 = 2 bits)
//   WM_Data             watermark bits, consumed on each accepted pixel
//   pix_in/_valid/_ready      input pixel stream
//   pix_out/_valid/_ready     output pixel stream, pix_out_last tags the
//                             final pixel of the frame
//   wm_adv              pulse per accepted pixel (WM_Data consumed)
//   busy                high whenever a frame is in progress
//   frame_done          one-cycle pulse once the last pixel has left
// ---------------------------------------------------------------------------
module wm_embed
  import wm_embed_pkg::*;
#(
  parameter int IMG_W = DEFAULT_IMG_W,
  parameter int IMG_H = DEFAULT_IMG_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             WM_select,
  input  logic [1:0]       WM_Data,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic             pix_out_last,
  output logic             wm_adv,
  output logic             busy,
  output logic             frame_done
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  state_t           state;
  logic             mode;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] embedded;
  logic             accept;
  logic             out_hs;
  logic             at_last;

  wm_lsb_insert u_insert (
    .mode    (mode),
    .wm_data (WM_Data),
    .pix_in  (pix_in),
    .pix_out (embedded)
  );

  // The output register may be refilled in the same cycle it is drained,
  // which is what gives one pixel per clock when downstream is ready.
  assign pix_in_ready = (state == RUN) && (!pix_out_valid || pix_out_ready);
  assign accept       = pix_in_valid && pix_in_ready;
  assign out_hs       = pix_out_valid && pix_out_ready;
  assign at_last      = (col == COL_MAX) && (row == ROW_MAX);

  assign wm_adv       = accept;
  assign busy         = (state != IDLE);
  assign frame_done   = (state == DONE);

  // FSM, raster counters and output register. The counters wrap to zero on
  // the final pixel so the row counter never runs past IMG_H-1; they are
  // also cleared on start so a frame always begins at the top-left pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mode          <= 1'b0;
      col           <= '0;
      row           <= '0;
      pix_out       <= '0;
      pix_out_valid <= 1'b0;
      pix_out_last  <= 1'b0;
    end else begin
      if (accept) begin
        pix_out       <= embedded;
        pix_out_valid <= 1'b1;
        pix_out_last  <= at_last;
      end else if (out_hs) begin
        pix_out_valid <= 1'b0;
        pix_out_last  <= 1'b0;
      end

      if (accept) begin
        if (col == COL_MAX) begin
          col <= '0;
          row <= at_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            mode  <= WM_select;
            col   <= '0;
            row   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept && at_last) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_hs) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wm_embed.sv
// ---------------------------------------------------------------------------
// tb_wm_embed
// Self-checking bench for wm_embed on a 4x2 frame. Expected pixels are
// pushed into a scoreboard queue when the bench sees an input handshake and
// popped when the DUT hands a pixel downstream.
// ---------------------------------------------------------------------------
module tb_wm_embed;

  localparam int W         = 4;
  localparam int H         = 2;
  localparam int FRAME_PIX = W * H;

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       WM_select;
  logic [1:0] WM_Data;
  logic [7:0] pix_in;
  logic       pix_in_valid;
  logic       pix_in_ready;
  logic [7:0] pix_out;
  logic       pix_out_valid;
  logic       pix_out_ready;
  logic       pix_out_last;
  logic       wm_adv;
  logic       busy;
  logic       frame_done;

  exp_t sb_q[$];
  logic model_mode;
  int   n_compared;
  int   n_mismatched;
  int   cycle;
  int   acc_in_frame;
  int   out_in_frame;
  int   out_total;
  int   adv_total;
  int   fd_total;
  int   fd_cycle;
  int   first_hs_cycle;
  int   last_hs_cycle;

  wm_embed #(.IMG_W(W), .IMG_H(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .WM_select     (WM_select),
    .WM_Data       (WM_Data),
    .pix_in        (pix_in),
    .pix_in_valid  (pix_in_valid),
    .pix_in_ready  (pix_in_ready),
    .pix_out       (pix_out),
    .pix_out_valid (pix_out_valid),
    .pix_out_ready (pix_out_ready),
    .pix_out_last  (pix_out_last),
    .wm_adv        (wm_adv),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference embedding applied to whatever the bench saw accepted.
  function automatic logic [7:0] embedModel(input logic m, input logic [7:0] p, input logic [1:0] w);
    return m ? {p[7:2], w} : {p[7:1], w[0]};
  endfunction

  // Scoreboard monitor, sampling on the falling edge. Outputs are popped
  // before the current input handshake is pushed, keeping FIFO order.
  initial begin
    exp_t e;
    cycle = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        sb_q.delete();
        acc_in_frame = 0;
        out_in_frame = 0;
      end else begin
        if (wm_adv) adv_total++;
        if (frame_done) begin
          fd_total++;
          fd_cycle = cycle;
        end
        if (pix_out_valid && pix_out_ready) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_out", 32'(pix_out), 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            checkOutput("pix_out", 32'(pix_out), 32'(e.pix));
            checkOutput("pix_last", 32'(pix_out_last), 32'(e.last));
          end
          out_total++;
          if (out_in_frame == 0) first_hs_cycle = cycle;
          if (out_in_frame == FRAME_PIX - 1) begin
            last_hs_cycle = cycle;
            out_in_frame  = 0;
          end else begin
            out_in_frame++;
          end
        end
        if (pix_in_valid && pix_in_ready) begin
          e.pix  = embedModel(model_mode, pix_in, WM_Data);
          e.last = (acc_in_frame == FRAME_PIX - 1);
          sb_q.push_back(e);
          acc_in_frame = e.last ? 0 : acc_in_frame + 1;
        end
      end
    end
  end

  // Pulse start for one cycle and record the mode the frame should use.
  task automatic startFrame(input logic sel);
    @(posedge clk);
    #1;
    WM_select  = sel;
    start      = 1'b1;
    model_mode = sel;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Drive the input stream until the frame completes or the budget expires.
  task automatic applyStimulus(input logic rnd, input logic [7:0] fix_pix,
                               input logic [1:0] fix_wm, input logic wm_toggle,
                               input int budget);
    int  fd_start;
    bit  done;
    fd_start = fd_total;
    done     = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (fd_total != fd_start) begin
        done = 1'b1;
        break;
      end
      if (rnd) begin
        pix_in_valid  = 1'($urandom_range(0, 1));
        pix_out_ready = 1'($urandom_range(0, 1));
        pix_in        = 8'($urandom);
        WM_Data       = 2'($urandom);
      end else begin
        pix_in_valid  = 1'b1;
        pix_out_ready = 1'b1;
        pix_in        = fix_pix;
        WM_Data       = wm_toggle ? (c[0] ? 2'b10 : 2'b11) : fix_wm;
      end
    end
    if (!done) checkOutput("frame_timeout", 32'd0, 32'd1);
    pix_in_valid  = 1'b0;
    pix_out_ready = 1'b1;
  endtask

  // Run the pixel stream until a given number of pixels have been accepted.
  task automatic runUntilAccepted(input int n);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (acc_in_frame >= n) break;
      pix_in_valid  = 1'b1;
      pix_out_ready = 1'b1;
      pix_in        = 8'($urandom);
      WM_Data       = 2'($urandom);
    end
    if (acc_in_frame < n) checkOutput("accept_timeout", 32'(acc_in_frame), 32'(n));
  endtask

  // Main sequence of scenarios.
  initial begin
    int fd0, out0, adv0;
    n_compared = 0; n_mismatched = 0;
    out_total = 0; adv_total = 0; fd_total = 0;
    fd_cycle = 0; first_hs_cycle = 0; last_hs_cycle = 0;
    acc_in_frame = 0; out_in_frame = 0;
    model_mode = 1'b0;
    rst = 1'b1; start = 1'b0; WM_select = 1'b0; WM_Data = 2'b00;
    pix_in = 8'h00; pix_in_valid = 1'b0; pix_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(pix_out_valid), 32'd0);
    checkOutput("rst_pix", 32'(pix_out), 32'd0);
    checkOutput("rst_last", 32'(pix_out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fd", 32'(frame_done), 32'd0);
    checkOutput("rst_adv", 32'(wm_adv), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_ready", 32'(pix_in_ready), 32'd0);

    // 2-bit mode, constant stream: eight 0xFD pixels back to back
    $display("[TB] frame 1: 2-bit mode, 0xFF / 01");
    fd0 = fd_total; out0 = out_total; adv0 = adv_total;
    startFrame(1'b1);
    checkOutput("run_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 8'hFF, 2'b01, 1'b0, 100);
    checkOutput("f1_outs", 32'(out_total - out0), 32'(FRAME_PIX));
    checkOutput("f1_adv", 32'(adv_total - adv0), 32'(FRAME_PIX));
    checkOutput("f1_fd", 32'(fd_total - fd0), 32'd1);
    checkOutput("f1_burst", 32'(last_hs_cycle - first_hs_cycle), 32'(FRAME_PIX - 1));
    checkOutput("f1_fd_lat", 32'(fd_cycle - last_hs_cycle), 32'd1);

    // 1-bit mode, 0xAA with WM_Data alternating 11/10 -> 0xAB / 0xAA
    $display("[TB] frame 2: 1-bit mode, 0xAA alternating watermark");
    fd0 = fd_total; out0 = out_total;
    startFrame(1'b0);
    applyStimulus(1'b0, 8'hAA, 2'b11, 1'b1, 100);
    checkOutput("f2_outs", 32'(out_total - out0), 32'(FRAME_PIX));
    checkOutput("f2_fd", 32'(fd_total - fd0), 32'd1);

    // Downstream stall with a pixel pending
    $display("[TB] frame 3: downstream stall");
    startFrame(1'b1);
    runUntilAccepted(2);
    pix_out_ready = 1'b0;
    adv0 = adv_total;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(pix_out_valid), 32'd1);
      if (sb_q.size() > 0) checkOutput("stall_pix", 32'(pix_out), 32'(sb_q[0].pix));
      else checkOutput("stall_pending", 32'(sb_q.size()), 32'd1);
      checkOutput("stall_in_ready", 32'(pix_in_ready), 32'd0);
      checkOutput("stall_adv", 32'(wm_adv), 32'd0);
    end
    checkOutput("stall_adv_cnt", 32'(adv_total - adv0), 32'd0);
    applyStimulus(1'b0, 8'h5C, 2'b10, 1'b0, 100);

    // Mode toggle and start pulse mid-frame are ignored
    $display("[TB] frame 4: mid-frame start / mode change");
    fd0 = fd_total; out0 = out_total;
    startFrame(1'b1);
    runUntilAccepted(3);
    WM_select = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    applyStimulus(1'b0, 8'h37, 2'b10, 1'b0, 100);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("f4_outs", 32'(out_total - out0), 32'(FRAME_PIX));
    checkOutput("f4_fd", 32'(fd_total - fd0), 32'd1);
    checkOutput("f4_busy", 32'(busy), 32'd0);

    // Reset after the third accepted pixel aborts the frame
    $display("[TB] frame 5: reset mid-frame");
    fd0 = fd_total;
    startFrame(1'b1);
    runUntilAccepted(3);
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(pix_out_valid), 32'd0);
    checkOutput("abort_pix", 32'(pix_out), 32'd0);
    checkOutput("abort_last", 32'(pix_out_last), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_adv", 32'(wm_adv), 32'd0);
    checkOutput("abort_in_ready", 32'(pix_in_ready), 32'd0);
    pix_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_fd", 32'(fd_total - fd0), 32'd0);
    fd0 = fd_total; out0 = out_total;
    startFrame(1'b0);
    applyStimulus(1'b0, 8'h81, 2'b01, 1'b0, 100);
    checkOutput("f5_outs", 32'(out_total - out0), 32'(FRAME_PIX));
    checkOutput("f5_fd", 32'(fd_total - fd0), 32'd1);

    // Random valid/ready on both sides
    $display("[TB] frame 6: random handshakes");
    fd0 = fd_total; out0 = out_total; adv0 = adv_total;
    startFrame(1'b1);
    applyStimulus(1'b1, 8'h00, 2'b00, 1'b0, 400);
    checkOutput("f6_adv", 32'(adv_total - adv0), 32'(FRAME_PIX));
    checkOutput("f6_outs", 32'(out_total - out0), 32'(FRAME_PIX));
    checkOutput("f6_fd", 32'(fd_total - fd0), 32'd1);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/wm_embed.md
WM_EMBED -- requirements
Module: wm_embed

Interface
REQ-001 Parameter IMG_W, default 256, pixels per line (2..4096).
REQ-002 Parameter IMG_H, default 256, lines per frame (1..4096).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a frame when idle.
REQ-006 WM_select  input  1  1 = embed 2 bits per pixel; 0 = embed 1 bit per pixel.
REQ-007 WM_Data  input  2  watermark bits from the generation stage.
REQ-008 pix_in  input  8  cover pixel, grayscale.
REQ-009 pix_in_valid  input  1  pix_in is valid.
REQ-010 pix_in_ready  output  1  block accepts pix_in this cycle.
REQ-011 pix_out  output  8  watermarked pixel.
REQ-012 pix_out_valid  output  1  pix_out is valid.
REQ-013 pix_out_ready  input  1  downstream accepts pix_out.
REQ-014 pix_out_last  output  1  pix_out is the frame's final pixel.
REQ-015 wm_adv  output  1  one-cycle pulse per accepted input pixel; marks WM_Data as consumed.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 frame_done  output  1  one-cycle pulse at frame completion.

Function
REQ-018 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-019 IDLE->RUN on start; latch WM_select into mode; clear col and row counters.
REQ-020 start outside IDLE shall be ignored, and WM_select changes after latching shall be ignored until the next frame.
REQ-021 Input handshake: a pixel is accepted when pix_in_valid && pix_in_ready.
REQ-022 pix_in_ready = (state==RUN) && (!pix_out_valid || pix_out_ready); it shall be 0 in IDLE, FLUSH and DONE.
REQ-023 On acceptance, WM_Data shall be sampled in the same cycle and wm_adv asserted in that cycle.
REQ-024 Embedding, mode=1: pix_out = {pix_in[7:2], WM_Data[1:0]}.
REQ-025 Embedding, mode=0: pix_out = {pix_in[7:1], WM_Data[0]}.
REQ-026 Latency: an accepted pixel shall appear on pix_out with pix_out_valid=1 on the next cycle.
REQ-027 pix_out, pix_out_valid and pix_out_last shall hold stable while pix_out_valid && !pix_out_ready.
REQ-028 pix_out_valid shall clear after an output handshake unless a new pixel is accepted in the same cycle.
REQ-029 Simultaneous output handshake and input acceptance shall give back-to-back throughput of one pixel per clock.
REQ-030 col increments per accepted pixel; at IMG_W-1 it wraps to 0 and row increments.
REQ-031 When the accepted pixel has col==IMG_W-1 and row==IMG_H-1, it shall be tagged pix_out_last and the FSM shall go RUN->FLUSH.
REQ-032 FLUSH->DONE on the output handshake of the last pixel.
REQ-033 In DONE, frame_done=1 for exactly one cycle, then the FSM goes DONE->IDLE.
REQ-034 Counter widths shall be clog2 of the parameter values; no overflow past IMG_H-1.

Reset
REQ-035 On rst, the FSM shall go to IDLE, and col, row, pix_out, pix_out_valid, pix_out_last, wm_adv, frame_done and busy shall all be 0; mode shall be 0.
REQ-036 rst mid-frame shall abort immediately, drop any pending output pixel and emit no frame_done.
REQ-037 The first start after rst release shall begin a fresh frame at col=0, row=0.

Structure
REQ-038 A shared package shall hold the FSM state encoding, the pixel width (8) and the default IMG_W/IMG_H constants.
REQ-039 One sub-module, wm_lsb_insert, shall implement the combinational mode-dependent bit substitution; the remaining logic (FSM, counters and output register) lives in wm_embed.

Verification
REQ-040 Use IMG_W=4, IMG_H=2, mode=1, pix_in=0xFF constant, WM_Data=2'b01, out_ready=1 -> eight outputs of 0xFD on consecutive cycles, pix_out_last on the 8th, and frame_done one cycle after the 8th handshake.
REQ-041 Set mode=0, pix_in=0xAA, WM_Data=2'b11 -> pix_out=0xAB; then WM_Data=2'b10 -> pix_out=0xAA.
REQ-042 Hold pix_out_ready=0 for 5 cycles with a pixel pending -> pix_out held stable, pix_in_ready=0, and no wm_adv pulses.
REQ-043 Toggle WM_select and pulse start mid-frame -> embedding mode unchanged, frame completes normally, and a single frame_done.
REQ-044 Assert rst after the 3rd accepted pixel -> all outputs 0 on the next edge and no frame_done; a new start then yields a full 8-pixel frame.
REQ-045 Drive random pix_in_valid/pix_out_ready (50%) -> every input pixel appears exactly once in order, and the wm_adv count equals 8.
